// File: rtl/e203_fpu_pkg.sv
// Shared FPU definitions: FSQRT front-end FSM states, canonical single-precision
// constants, fflags bit positions and the operand class one-hot bit positions.
package e203_fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_RESP = 2'd2
  } fsqrt_state_e;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  // fflags = {NV,DZ,OF,UF,NX}
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  // One-hot operand classes as seen by square root
  localparam int CLS_ZERO = 0;  // +/-0
  localparam int CLS_SUB  = 1;  // +/- subnormal
  localparam int CLS_INF  = 2;  // +inf only
  localparam int CLS_QNAN = 3;
  localparam int CLS_SNAN = 4;
  localparam int CLS_NEG  = 5;  // negative normal or -inf
  localparam int CLS_POSN = 6;  // positive normal
  localparam int CLS_W    = 7;

endpackage

// File: rtl/e203_exu_fpu_fsqrt_pre_if.sv
// FSQRT pre-stage bundle: upstream operand, sqrt core issue/result, writeback.
// slave = the pre-stage itself, master = the surrounding EXU / core / bench.
interface e203_exu_fpu_fsqrt_pre_if;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_rs1;
  logic        sqrt_i_valid;
  logic        sqrt_i_ready;
  logic [31:0] sqrt_rs1;
  logic        sqrt_o_valid;
  logic        sqrt_o_ready;
  logic [31:0] sqrt_wdat;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_wdat;
  logic [4:0]  o_fflags;

  modport slave (
    input  i_valid, i_rs1, sqrt_i_ready, sqrt_o_valid, sqrt_wdat, o_ready,
    output i_ready, sqrt_i_valid, sqrt_rs1, sqrt_o_ready, o_valid, o_wdat, o_fflags
  );

  modport master (
    output i_valid, i_rs1, sqrt_i_ready, sqrt_o_valid, sqrt_wdat, o_ready,
    input  i_ready, sqrt_i_valid, sqrt_rs1, sqrt_o_ready, o_valid, o_wdat, o_fflags
  );
endinterface

// File: rtl/e203_fpu_fclass32.sv
// Single-precision operand classifier for square root, one-hot class output.
// Latency: purely combinational.
// Backpressure: none (no handshake).
import e203_fpu_pkg::*;

module e203_fpu_fclass32 (
  input  logic [31:0]       x_i,
  output logic [CLS_W-1:0]  cls_o
);
  logic       sign;
  logic [7:0] expo;
  logic       man_nz;
  logic       exp_zero;
  logic       exp_ones;

  assign sign     = x_i[31];
  assign expo     = x_i[30:23];
  assign man_nz   = |x_i[22:0];
  assign exp_zero = (expo == 8'h00);
  assign exp_ones = (expo == 8'hFF);

  // Exactly one class bit is set for any 32-bit pattern
  always_comb begin
    cls_o           = '0;
    cls_o[CLS_ZERO] = exp_zero & ~man_nz;
    cls_o[CLS_SUB]  = exp_zero &  man_nz;
    cls_o[CLS_INF]  = exp_ones & ~man_nz & ~sign;
    cls_o[CLS_QNAN] = exp_ones &  man_nz &  x_i[22];
    cls_o[CLS_SNAN] = exp_ones &  man_nz & ~x_i[22];
    cls_o[CLS_NEG]  = sign & ((~exp_zero & ~exp_ones) | (exp_ones & ~man_nz));
    cls_o[CLS_POSN] = ~sign & ~exp_zero & ~exp_ones;
  end
endmodule

// File: rtl/e203_exu_fpu_fsqrt_pre.sv
// FSQRT.S pre-stage: resolves special operands locally, forwards positive normals
// to the sqrt core. Latency: 1 cycle accept->o_valid for specials, core latency +1 otherwise.
// Backpressure: one op in flight; i_ready only in IDLE, result held in RESP until o_ready.
// Optional feature macro: E203_FSQRT_FFLAGS_EN (NV flag generation; default off, fflags tied 0).
import e203_fpu_pkg::*;

module e203_exu_fpu_fsqrt_pre (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  e203_exu_fpu_fsqrt_pre_if.slave     bus
);
  fsqrt_state_e     state_q;
  logic [31:0]      op_q;
  logic [31:0]      res_q;
  logic [CLS_W-1:0] cls;
  logic [31:0]      spc_res;
  logic             accept;

  e203_fpu_fclass32 u_fclass (
    .x_i   (bus.i_rs1),
    .cls_o (cls)
  );

  assign accept = bus.i_valid & (state_q == ST_IDLE);

  // Special-case result for every class that bypasses the core
  always_comb begin
    spc_res = QNAN;
    case (1'b1)
      cls[CLS_ZERO], cls[CLS_SUB]: spc_res = {bus.i_rs1[31], 31'd0};
      cls[CLS_INF]:                spc_res = PINF;
      cls[CLS_QNAN], cls[CLS_SNAN], cls[CLS_NEG]: spc_res = QNAN;
      default:                     spc_res = QNAN;
    endcase
  end

`ifdef E203_FSQRT_FFLAGS_EN
  logic [4:0] flags_q;
  logic [4:0] spc_flags;

  // Invalid only for signalling NaN and negative non-zero operands
  always_comb begin
    spc_flags           = 5'd0;
    spc_flags[FFLAG_NV] = cls[CLS_SNAN] | cls[CLS_NEG];
  end
`endif

  // Control FSM with operand/result registers; flush beats every handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 32'd0;
      res_q   <= 32'd0;
`ifdef E203_FSQRT_FFLAGS_EN
      flags_q <= 5'd0;
`endif
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (cls[CLS_POSN]) begin
              op_q    <= bus.i_rs1;
              state_q <= ST_CORE;
            end else begin
              res_q   <= spc_res;
`ifdef E203_FSQRT_FFLAGS_EN
              flags_q <= spc_flags;
`endif
              state_q <= ST_RESP;
            end
          end
        end
        ST_CORE: begin
          if (bus.sqrt_o_valid) begin
            res_q   <= bus.sqrt_wdat;
`ifdef E203_FSQRT_FFLAGS_EN
            flags_q <= 5'd0;
`endif
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.o_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register
  assign bus.i_ready      = (state_q == ST_IDLE);
  assign bus.sqrt_i_valid = (state_q == ST_CORE);
  assign bus.sqrt_o_ready = (state_q == ST_CORE);
  assign bus.sqrt_rs1     = op_q;
  assign bus.o_valid      = (state_q == ST_RESP);
  assign bus.o_wdat       = res_q;
`ifdef E203_FSQRT_FFLAGS_EN
  assign bus.o_fflags     = flags_q;
`else
  assign bus.o_fflags     = 5'd0;
`endif
endmodule

// File: tb/tb_e203_exu_fpu_fsqrt_pre.sv
// Self-checking bench for the FSQRT.S pre-stage: directed corner cases,
// flush/reset aborts, then randomized operands against a field-level reference model.
module tb_e203_exu_fpu_fsqrt_pre;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  e203_exu_fpu_fsqrt_pre_if bus ();

  e203_exu_fpu_fsqrt_pre dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef E203_FSQRT_FFLAGS_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: returns {goes_to_core, nv, special_result}
  function automatic logic [33:0] ref_model(input logic [31:0] x);
    logic        s;
    int unsigned e;
    int unsigned m;
    s = x[31];
    e = (x >> 23) & 32'hFF;
    m = x & 32'h7FFFFF;
    if (e == 255 && m != 0) return {1'b0, (m < 32'h400000), 32'h7FC00000};
    if (e == 0)             return {1'b0, 1'b0, (s ? 32'h80000000 : 32'h0)};
    if (s)                  return {1'b0, 1'b1, 32'h7FC00000};
    if (e == 255)           return {1'b0, 1'b0, 32'h7F800000};
    return {1'b1, 1'b0, 32'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation: accept, optional core round trip, stalled writeback, drain
  task automatic run_op(input string tag, input logic [31:0] x, input int core_lat,
                        input logic [31:0] core_res, input int stall);
    logic [33:0] r;
    logic [31:0] exp_w;
    logic [4:0]  exp_f;
    r = ref_model(x);
    chk({tag, "_iready"}, bus.i_ready, 1);
    bus.i_valid = 1'b1;
    bus.i_rs1   = x;
    tick();
    bus.i_valid = 1'b0;
    bus.i_rs1   = $urandom;
    if (r[33]) begin
      chk({tag, "_sqiv"}, bus.sqrt_i_valid, 1);
      chk({tag, "_sqrs1"}, bus.sqrt_rs1, x);
      chk({tag, "_sqordy"}, bus.sqrt_o_ready, 1);
      for (int i = 0; i < core_lat; i++) begin
        tick();
        chk({tag, "_sqrs1_hold"}, bus.sqrt_rs1, x);
        chk({tag, "_ov_core"}, bus.o_valid, 0);
      end
      bus.sqrt_o_valid = 1'b1;
      bus.sqrt_wdat    = core_res;
      tick();
      bus.sqrt_o_valid = 1'b0;
      bus.sqrt_wdat    = $urandom;
      exp_w = core_res;
      exp_f = 5'd0;
    end else begin
      exp_w = r[31:0];
      exp_f = (FF_EN && r[32]) ? 5'b10000 : 5'b00000;
    end
    chk({tag, "_sqiv_off"}, bus.sqrt_i_valid, 0);
    chk({tag, "_ovalid"}, bus.o_valid, 1);
    chk({tag, "_owdat"}, bus.o_wdat, exp_w);
    chk({tag, "_fflags"}, {27'd0, bus.o_fflags}, {27'd0, exp_f});
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_ov"}, bus.o_valid, 1);
      chk({tag, "_stall_wdat"}, bus.o_wdat, exp_w);
      chk({tag, "_stall_ff"}, {27'd0, bus.o_fflags}, {27'd0, exp_f});
      chk({tag, "_stall_irdy"}, bus.i_ready, 0);
    end
    // A new operand offered while RESP drains must not be taken
    bus.o_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_rs1   = 32'h40800000;
    tick();
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b0;
    chk({tag, "_drain_ov"}, bus.o_valid, 0);
    chk({tag, "_drain_sqiv"}, bus.sqrt_i_valid, 0);
    chk({tag, "_drain_irdy"}, bus.i_ready, 1);
  endtask

  initial begin
    logic [31:0] x;
    int          sel;
    bus.i_valid      = 1'b0;
    bus.i_rs1        = 32'd0;
    bus.sqrt_i_ready = 1'b1;
    bus.sqrt_o_valid = 1'b0;
    bus.sqrt_wdat    = 32'd0;
    bus.o_ready      = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_irdy", bus.i_ready, 1);
    chk("rst_sqiv", bus.sqrt_i_valid, 0);
    chk("rst_sqordy", bus.sqrt_o_ready, 0);
    chk("rst_sqrs1", bus.sqrt_rs1, 0);
    chk("rst_ov", bus.o_valid, 0);
    chk("rst_wdat", bus.o_wdat, 0);
    chk("rst_ff", {27'd0, bus.o_fflags}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed corner cases
    run_op("sqrt4",  32'h40800000, 3, 32'h40000000, 0);
    run_op("neg4",   32'hC0800000, 0, 32'h0, 0);
    run_op("nzero",  32'h80000000, 0, 32'h0, 0);
    run_op("pzero",  32'h00000000, 0, 32'h0, 0);
    run_op("subn",   32'h00000001, 0, 32'h0, 1);
    run_op("nsubn",  32'h807FFFFF, 0, 32'h0, 0);
    run_op("snan",   32'h7F800001, 0, 32'h0, 0);
    run_op("qnan",   32'hFFC00001, 0, 32'h0, 0);
    run_op("pinf",   32'h7F800000, 0, 32'h0, 0);
    run_op("ninf",   32'hFF800000, 0, 32'h0, 0);
    run_op("stall5", 32'h3F800000, 0, 32'h3F800000, 5);

    // Flush in CORE in the same cycle the core answers
    bus.i_valid = 1'b1;
    bus.i_rs1   = 32'h40800000;
    tick();
    bus.i_valid = 1'b0;
    chk("fl_core_sqiv", bus.sqrt_i_valid, 1);
    flush = 1'b1;
    bus.sqrt_o_valid = 1'b1;
    bus.sqrt_wdat    = 32'h40000000;
    tick();
    flush = 1'b0;
    bus.sqrt_o_valid = 1'b0;
    chk("fl_core_irdy", bus.i_ready, 1);
    chk("fl_core_ov", bus.o_valid, 0);
    chk("fl_core_sqiv0", bus.sqrt_i_valid, 0);
    tick();
    chk("fl_core_ov2", bus.o_valid, 0);

    // Flush in RESP beats o_ready and an offered operand
    bus.i_valid = 1'b1;
    bus.i_rs1   = 32'hC0800000;
    tick();
    chk("fl_resp_ov", bus.o_valid, 1);
    flush = 1'b1;
    bus.o_ready = 1'b1;
    tick();
    flush = 1'b0;
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b0;
    chk("fl_resp_ov0", bus.o_valid, 0);
    chk("fl_resp_irdy", bus.i_ready, 1);

    // Reset during RESP drops o_valid without waiting for a clock
    bus.i_valid = 1'b1;
    bus.i_rs1   = 32'hC0800000;
    tick();
    bus.i_valid = 1'b0;
    chk("rs_resp_ov", bus.o_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_async_ov", bus.o_valid, 0);
    chk("rs_async_wdat", bus.o_wdat, 0);
    chk("rs_async_irdy", bus.i_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rs_after_ov", bus.o_valid, 0);

    // Reset during CORE discards the operation
    bus.i_valid = 1'b1;
    bus.i_rs1   = 32'h41100000;
    tick();
    bus.i_valid = 1'b0;
    chk("rc_sqiv", bus.sqrt_i_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rc_sqiv0", bus.sqrt_i_valid, 0);
    chk("rc_sqrs1", bus.sqrt_rs1, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.sqrt_o_valid = 1'b1;
    tick();
    bus.sqrt_o_valid = 1'b0;
    chk("rc_ov", bus.o_valid, 0);

    // Randomized operands across all classes
    for (int n = 0; n < 60; n++) begin
      x   = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: x[30:23] = 8'h00;
        1: x[30:23] = 8'hFF;
        2: x[22:0]  = 23'd0;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) x[31] = 1'b0;
      run_op("rnd", x, $urandom_range(0, 4), $urandom, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time guard so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/e203_exu_fpu_fsqrt_pre.md
E203_EXU_FPU_FSQRT_PRE -- requirements
Module: e203_exu_fpu_fsqrt_pre

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port flush, input, 1: pipeline flush pulse from the EXU.
REQ-004 SHALL have ports i_valid input 1 / i_ready output 1 / i_rs1 input 32: upstream FSQRT.S operand handshake.
REQ-005 SHALL have ports sqrt_i_valid output 1 / sqrt_i_ready input 1 / sqrt_rs1 output 32: issue to the fmis sqrt core.
REQ-006 SHALL have ports sqrt_o_valid input 1 / sqrt_o_ready output 1 / sqrt_wdat input 32: sqrt core result.
REQ-007 SHALL have ports o_valid output 1 / o_ready input 1 / o_wdat output 32 / o_fflags output 5 ({NV,DZ,OF,UF,NX}): writeback handshake.

Function
REQ-008 SHALL implement FSM states IDLE, CORE, RESP; encoding 2 bits.
REQ-009 SHALL assert i_ready only in IDLE; accept when i_valid & i_ready.
REQ-010 SHALL classify the accepted operand combinationally: zero, subnormal, inf, qNaN, sNaN, negative-nonzero, positive-normal.
REQ-011 SHALL, for positive-normal, latch operand into op_q and go IDLE->CORE.
REQ-012 SHALL, for all other classes, latch the special result into res_q and go IDLE->RESP (o_valid one cycle after accept).
REQ-013 SHALL produce special results: +/-0 -> same signed zero; subnormal -> signed zero (flush-to-zero); +inf -> 32'h7F800000; NaN or negative-nonzero (incl. -inf) -> 32'h7FC00000.
REQ-014 SHALL, in CORE, drive sqrt_i_valid=1, sqrt_rs1=op_q, sqrt_o_ready=1; op_q held stable throughout.
REQ-015 SHALL, in CORE, on sqrt_o_valid capture sqrt_wdat into res_q with fflags 0, go CORE->RESP; sqrt_i_ready is ignored for state progression.
REQ-016 SHALL, in RESP, drive o_valid=1, o_wdat=res_q, o_fflags=flags_q; on o_ready go RESP->IDLE.
REQ-017 SHALL keep sqrt_i_valid, sqrt_o_ready, o_valid at 0 outside their states; sqrt_rs1 = op_q always.
REQ-018 SHALL, on flush, go to IDLE from any state next cycle; flush has priority over every handshake in the same cycle; no output for the flushed op.
REQ-019 SHALL not accept a new operand in the cycle RESP completes (i_ready follows registered state only).
REQ-020 SHALL hold o_wdat/o_fflags stable while o_valid=1 and o_ready=0.

Reset
REQ-021 SHALL on rst set state=IDLE, op_q=0, res_q=0, flags_q=0; hence i_ready=1, all other outputs 0.
REQ-022 SHALL on rst mid-operation (CORE or RESP) discard the operation with no o_valid pulse.

Configuration
REQ-023 SHALL, with E203_FSQRT_FFLAGS_EN defined, set flags_q NV=1 for sNaN and negative-nonzero inputs, all other bits 0.
REQ-024 SHALL, without E203_FSQRT_FFLAGS_EN, tie o_fflags to 5'b0 and omit flags_q.

Structure
REQ-025 SHALL place FSM state encodings, canonical constants (QNAN 32'h7FC00000, PINF 32'h7F800000) and fflags bit indices in shared package e203_fpu_pkg.
REQ-026 SHALL implement classification in sub-module e203_fpu_fclass32 (pure combinational, 32-bit in, one-hot class out).

Verification
REQ-027 SHALL cover: i_rs1=32'h40800000 (4.0) -> sqrt_i_valid next cycle with sqrt_rs1=32'h40800000; core returns 32'h40000000 -> o_valid, o_wdat=32'h40000000, fflags 0.
REQ-028 SHALL cover: i_rs1=32'hC0800000 (-4.0) -> o_valid cycle after accept, o_wdat=32'h7FC00000, o_fflags=5'b10000 (macro on) / 5'b0 (off); sqrt_i_valid never asserted.
REQ-029 SHALL cover: i_rs1=32'h80000000 -> o_wdat=32'h80000000; i_rs1=32'h00000001 -> o_wdat=0; i_rs1=32'h7F800001 -> 32'h7FC00000 with NV.
REQ-030 SHALL cover: result in RESP with o_ready=0 for 5 cycles -> o_wdat stable, i_ready=0; o_ready=1 -> IDLE, i_ready=1 next cycle.
REQ-031 SHALL cover: flush asserted in CORE in the same cycle as sqrt_o_valid -> IDLE, no o_valid; rst asserted in RESP -> o_valid drops asynchronously.
